// File: rtl/maze_store.sv
// maze_store: wall/visited cell store for the maze solver, with serial host load
// and a post-solve dump of every visited cell plus the path length.
module maze_store #(
    parameter int maze_width = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    input  logic                  load_wall,
    output logic                  load_ready,
    output logic                  maze_ready,
    input  logic [maze_width-1:0] row,
    input  logic [maze_width-1:0] col,
    input  logic                  maze_oe,
    input  logic                  maze_we,
    output logic                  maze_in,
    input  logic                  done,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [maze_width-1:0] dump_row,
    output logic [maze_width-1:0] dump_col,
    output logic                  dump_last,
    output logic                  dump_complete,
    output logic [2*maze_width:0] path_len
);
    localparam int aw = 2 * maze_width;
    localparam int C  = 2 ** aw;

    typedef enum logic [1:0] {LOAD, SOLVE, DUMP, FINISHED} state_t;

    state_t          state;
    logic [C-1:0]    wall;
    logic [C-1:0]    visited;
    logic [aw-1:0]   addr_cnt;
    logic [aw-1:0]   scan;
    logic [aw-1:0]   addr;
    logic [aw:0]     emitted;
    logic            load_fire;
    logic            we_ok;

    assign addr          = {row, col};
    assign load_ready    = rst_n && (state == LOAD);
    assign maze_ready    = (state != LOAD);
    assign dump_complete = (state == FINISHED);
    assign load_fire     = load_valid && load_ready;
    assign we_ok         = (state == SOLVE) && maze_we && !wall[addr] && !visited[addr];

    // Cell array is never reset; a full load rewrites every cell.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            wall[addr_cnt]    <= load_wall;
            visited[addr_cnt] <= 1'b0;
        end else if (we_ok) begin
            visited[addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            addr_cnt   <= '0;
            scan       <= '0;
            emitted    <= '0;
            maze_in    <= 1'b0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            dump_row   <= '0;
            dump_col   <= '0;
            path_len   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_fire) begin
                        addr_cnt <= addr_cnt + 1'b1;
                        if (&addr_cnt) state <= SOLVE;
                    end
                end
                SOLVE: begin
                    if (maze_oe) maze_in <= wall[addr];
                    if (we_ok) path_len <= path_len + 1'b1;
                    if (done) begin
                        state <= DUMP;
                        scan  <= '0;
                    end
                end
                DUMP: begin
                    // A pending beat freezes the scan until it is accepted.
                    if (dump_valid) begin
                        if (dump_ready) begin
                            dump_valid <= 1'b0;
                            dump_last  <= 1'b0;
                            if (dump_last) state <= FINISHED;
                        end
                    end else if (path_len == '0) begin
                        state <= FINISHED;
                    end else begin
                        scan <= scan + 1'b1;
                        if (visited[scan]) begin
                            dump_valid           <= 1'b1;
                            {dump_row, dump_col} <= scan;
                            dump_last            <= (emitted + 1'b1 == path_len);
                            emitted              <= emitted + 1'b1;
                        end
                    end
                end
                FINISHED: begin
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_store.sv
// tb_maze_store: randomized scoreboard bench for maze_store against an
// array-based model of the cell store and the expected visited-cell dump order.
module tb_maze_store;
    localparam int W = 6;
    localparam int N = 64;
    localparam int C = N * N;

    logic           clk = 0;
    logic           rst_n = 0;
    logic           load_valid = 0;
    logic           load_wall = 0;
    logic           maze_oe = 0;
    logic           maze_we = 0;
    logic           done = 0;
    logic           dump_ready = 0;
    logic [W-1:0]   row = 0;
    logic [W-1:0]   col = 0;
    logic           load_ready, maze_ready, maze_in;
    logic           dump_valid, dump_last, dump_complete;
    logic [W-1:0]   dump_row, dump_col;
    logic [2*W:0]   path_len;

    bit             wall_m[C];
    bit             vis_m[C];
    int             plen;
    bit             mi_m;
    int             checks = 0;
    int             failures = 0;
    logic [31:0]    exp_q[$];

    maze_store #(.maze_width(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_wall(load_wall), .load_ready(load_ready),
        .maze_ready(maze_ready),
        .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we), .maze_in(maze_in),
        .done(done),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_row(dump_row), .dump_col(dump_col), .dump_last(dump_last),
        .dump_complete(dump_complete), .path_len(path_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && dump_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dump_unexpected row=%0d col=%0d", dump_row, dump_col);
            end else begin
                chk("dump_beat", {19'd0, dump_row, dump_col, dump_last}, exp_q[0]);
                if (dump_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_reset;
        rst_n = 0;
        exp_q.delete();
        {load_valid, load_wall, maze_oe, maze_we, done, dump_ready} = '0;
        row = 0;
        col = 0;
        mi_m = 0;
        tick;
        chk("rst_maze_ready", maze_ready, 0);
        chk("rst_path_len", path_len, 0);
        chk("rst_dump", {dump_valid, dump_last, dump_complete, maze_in}, 0);
        rst_n = 1;
        #1;
        chk("rst_load_ready", load_ready, 1);
        tick;
    endtask

    task automatic do_load(input bit diag, input bit gaps, input bit extra);
        int i;
        int n;
        i = 0;
        n = 0;
        for (int a = 0; a < C; a++) begin
            wall_m[a] = diag ? (a / N == a % N) : ($urandom_range(0, 3) == 0);
            vis_m[a] = 0;
        end
        plen = 0;
        while (i < C && n < 4 * C) begin
            load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            load_wall = wall_m[i];
            if (load_valid && load_ready) i++;
            tick;
            n++;
        end
        load_valid = 0;
        chk("load_beats", i, C);
        chk("load_ready_drop", load_ready, 0);
        chk("maze_ready_rise", maze_ready, 1);
        if (extra) begin
            load_wall = 0;
            load_valid = 1;
            repeat (5) tick;
            load_valid = 0;
        end
    endtask

    task automatic rd(input int r, input int c);
        row = W'(r);
        col = W'(c);
        maze_oe = 1;
        tick;
        maze_oe = 0;
        mi_m = wall_m[r * N + c];
        chk("maze_in", maze_in, mi_m);
    endtask

    task automatic wr(input int r, input int c, input bit oe);
        int a;
        a = r * N + c;
        row = W'(r);
        col = W'(c);
        maze_we = 1;
        maze_oe = oe;
        tick;
        {maze_we, maze_oe} = '0;
        if (!wall_m[a] && !vis_m[a]) begin
            vis_m[a] = 1;
            plen++;
        end
        chk("path_len", path_len, plen);
        if (oe) begin
            mi_m = wall_m[a];
            chk("maze_in_we", maze_in, mi_m);
        end
    endtask

    task automatic build_q;
        int k;
        k = 0;
        for (int a = 0; a < C; a++) begin
            if (vis_m[a]) begin
                k++;
                exp_q.push_back((a << 1) | int'(k == plen));
            end
        end
    endtask

    task automatic finish_dump(input bit rnd);
        int n;
        bit prev;
        n = 0;
        while (!dump_complete && n < 3 * C) begin
            dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            prev = dump_valid && dump_last && dump_ready;
            tick;
            n++;
            if (prev) chk("complete_timing", dump_complete, 1);
        end
        dump_ready = 0;
        chk("dump_complete", dump_complete, 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("dump_valid_end", dump_valid, 0);
        chk("path_len_hold", path_len, plen);
        chk("maze_in_hold", maze_in, mi_m);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int a;
        // Diagonal maze: reads, overrun load, directed writes, stalled dump.
        do_reset;
        do_load(1, 0, 1);
        rd(3, 3);
        rd(3, 4);
        rd(0, 0);
        row = 1;
        col = 2;
        tick;
        chk("maze_in_idle_hold", maze_in, mi_m);
        wr(5, 4, 0);
        wr(5, 6, 1);
        wr(5, 4, 0);
        wr(2, 2, 1);
        rd(5, 4);
        build_q;
        done = 1;
        k = 0;
        do begin
            tick;
            done = 0;
            k++;
        end while (!dump_valid && k < C + 10);
        chk("dump_latency", k, 5 * N + 4 + 2);
        repeat (3) begin
            tick;
            chk("dump_stall_valid", dump_valid, 1);
        end
        finish_dump(0);

        // Random maze with gapped load, random solver traffic, random backpressure.
        do_reset;
        do_load(0, 1, 0);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) rd($urandom_range(0, N - 1), $urandom_range(0, N - 1));
            else wr($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
        end
        build_q;
        done = 1;
        tick;
        done = 0;
        finish_dump(1);

        // No visited cells: dump finishes without emitting a beat.
        do_reset;
        do_load(0, 1, 0);
        rd(1, 1);
        done = 1;
        tick;
        done = 0;
        tick;
        chk("empty_complete", dump_complete, 1);
        chk("empty_path_len", path_len, 0);
        chk("empty_no_valid", dump_valid, 0);

        // Reset while a dump beat is pending.
        do_reset;
        do_load(0, 0, 0);
        a = 0;
        while (a < C - 1 && !wall_m[a]) a++;
        rd(a / N, a % N);
        for (int i = 0; i < 20; i++) wr($urandom_range(0, 7), $urandom_range(0, 7), 0);
        a = 0;
        while (a < C - 1 && wall_m[a]) a++;
        wr(a / N, a % N, 0);
        build_q;
        done = 1;
        tick;
        done = 0;
        k = 0;
        while (!dump_valid && k < C + 10) begin
            tick;
            k++;
        end
        chk("pre_reset_valid", dump_valid, 1);
        #2;
        rst_n = 0;
        exp_q.delete();
        #1;
        chk("async_rst_flags", {dump_valid, dump_last, dump_complete, maze_in, maze_ready, load_ready}, 0);
        chk("async_rst_coords", {dump_row, dump_col}, 0);
        chk("async_rst_path_len", path_len, 0);
        tick;
        rst_n = 1;
        #1;
        chk("post_rst_load_ready", load_ready, 1);
        chk("post_rst_maze_ready", maze_ready, 0);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
